// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin/change codes, upstream FSM state
// constants, the dispenser state enum and change-code decode helpers.
package vend_pkg;

  // Change codes sent from the vending FSM to the dispenser
  localparam logic [2:0] CHANGE_NONE = 3'b000;
  localparam logic [2:0] NICKEL      = 3'b001;
  localparam logic [2:0] DIME        = 3'b010;
  localparam logic [2:0] NICKEL_DIME = 3'b011;
  localparam logic [2:0] DIME_DIME   = 3'b100;

  // Coin-acceptor codes seen by the upstream FSM
  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;
  localparam logic [1:0] QUARTER     = 2'b11;

  // Upstream FSM states: credit accumulated so far, in cents
  localparam logic [2:0] VM_S0  = 3'd0;
  localparam logic [2:0] VM_S5  = 3'd1;
  localparam logic [2:0] VM_S10 = 3'd2;
  localparam logic [2:0] VM_S15 = 3'd3;
  localparam logic [2:0] VM_S20 = 3'd4;

  typedef enum logic [2:0] {
    DISP_IDLE         = 3'd0,
    DISP_RELEASE      = 3'd1,
    DISP_DIME_PULSE   = 3'd2,
    DISP_DIME_WAIT    = 3'd3,
    DISP_NICKEL_PULSE = 3'd4,
    DISP_NICKEL_WAIT  = 3'd5,
    DISP_FAULT        = 3'd6
  } disp_state_e;

  typedef struct packed {
    logic [1:0] dimes;
    logic [1:0] nickels;
  } coin_count_t;

  function automatic logic change_illegal(input logic [2:0] code);
    return code > DIME_DIME;
  endfunction

  function automatic coin_count_t decode_change(input logic [2:0] code);
    coin_count_t r;
    r = '0;
    case (code)
      NICKEL:      r.nickels = 2'd1;
      DIME:        r.dimes   = 2'd1;
      NICKEL_DIME: begin r.dimes = 2'd1; r.nickels = 2'd1; end
      DIME_DIME:   r.dimes   = 2'd2;
      default:     r = '0;
    endcase
    return r;
  endfunction

  // Dimes go out before nickels; nothing left means the transaction is done
  function automatic disp_state_e coin_state(input logic [1:0] dimes,
                                             input logic [1:0] nickels);
    if (dimes != 2'd0)   return DISP_DIME_PULSE;
    if (nickels != 2'd0) return DISP_NICKEL_PULSE;
    return DISP_IDLE;
  endfunction

endpackage

// File: rtl/drop_sync.sv
// Chute sensor conditioner: 2-flop synchronizer, then a registered one-clock
// pulse on each rising edge of the synchronized level.
module drop_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       pulse_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], din_i};
      prev_q  <= sync_q[1];
      pulse_q <= sync_q[1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/coin_change_dispenser.sv
// Product/change dispenser: captures a vend request, pulses the product, dime
// and nickel solenoids in turn, and waits for each coin's drop sensor.
import vend_pkg::*;

module coin_change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vend,
  input  logic [2:0] change,
  input  logic       nickel_drop,
  input  logic       dime_drop,
  input  logic       fault_clear,
  output logic       product_release,
  output logic       dime_eject,
  output logic       nickel_eject,
  output logic       busy,
  output logic       fault,
  output logic [2:0] state_dbg
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  disp_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dimes_q, dimes_d;
  logic [1:0]    nickels_q, nickels_d;
  logic          release_q, dime_q, nickel_q, busy_q, fault_q;
  logic          dime_edge, nickel_edge;
  coin_count_t   req_count;

  drop_sync u_dime_sync (
    .clk_i   (clock),
    .rst_i   (reset),
    .din_i   (dime_drop),
    .pulse_o (dime_edge)
  );

  drop_sync u_nickel_sync (
    .clk_i   (clock),
    .rst_i   (reset),
    .din_i   (nickel_drop),
    .pulse_o (nickel_edge)
  );

  assign req_count = decode_change(change);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= DISP_IDLE;
      cnt_q     <= '0;
      dimes_q   <= 2'd0;
      nickels_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dimes_q   <= dimes_d;
      nickels_q <= nickels_d;
    end
  end

  // A request is vend or any nonzero change code, and is looked at only in IDLE;
  // the counter is reloaded on every state change and counts down otherwise.
  always_comb begin
    state_d   = state_q;
    dimes_d   = dimes_q;
    nickels_d = nickels_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
    case (state_q)
      DISP_IDLE: begin
        if (vend || (change != CHANGE_NONE)) begin
          if (change_illegal(change)) begin
            dimes_d   = 2'd0;
            nickels_d = 2'd0;
            state_d   = DISP_FAULT;
          end else begin
            dimes_d   = req_count.dimes;
            nickels_d = req_count.nickels;
            state_d   = vend ? DISP_RELEASE : coin_state(req_count.dimes, req_count.nickels);
          end
        end
      end
      DISP_RELEASE: begin
        if (cnt_q == '0) state_d = coin_state(dimes_q, nickels_q);
      end
      DISP_DIME_PULSE: begin
        if (cnt_q == '0) state_d = DISP_DIME_WAIT;
      end
      DISP_DIME_WAIT: begin
        // A drop landing on the expiry cycle still counts as a drop
        if (dime_edge) begin
          dimes_d = dimes_q - 2'd1;
          state_d = coin_state(dimes_d, nickels_q);
        end else if (cnt_q == '0) begin
          state_d = DISP_FAULT;
        end
      end
      DISP_NICKEL_PULSE: begin
        if (cnt_q == '0) state_d = DISP_NICKEL_WAIT;
      end
      DISP_NICKEL_WAIT: begin
        if (nickel_edge) begin
          nickels_d = nickels_q - 2'd1;
          state_d   = (nickels_d != 2'd0) ? DISP_NICKEL_PULSE : DISP_IDLE;
        end else if (cnt_q == '0) begin
          state_d = DISP_FAULT;
        end
      end
      DISP_FAULT: begin
        dimes_d   = 2'd0;
        nickels_d = 2'd0;
        if (fault_clear) state_d = DISP_IDLE;
      end
      default: state_d = DISP_IDLE;
    endcase
    if (state_d != state_q) begin
      case (state_d)
        DISP_RELEASE, DISP_DIME_PULSE, DISP_NICKEL_PULSE: cnt_d = PULSE_LOAD;
        DISP_DIME_WAIT, DISP_NICKEL_WAIT:                 cnt_d = TIMEOUT_LOAD;
        default:                                          cnt_d = '0;
      endcase
    end
  end

  // Actuators are decoded from the state register one clock later, so every
  // output comes straight from a flop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      release_q <= 1'b0;
      dime_q    <= 1'b0;
      nickel_q  <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      release_q <= (state_q == DISP_RELEASE);
      dime_q    <= (state_q == DISP_DIME_PULSE);
      nickel_q  <= (state_q == DISP_NICKEL_PULSE);
      busy_q    <= (state_q != DISP_IDLE);
      fault_q   <= (state_q == DISP_FAULT);
    end
  end

  assign product_release = release_q;
  assign dime_eject      = dime_q;
  assign nickel_eject    = nickel_q;
  assign busy            = busy_q;
  assign fault           = fault_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed bench for coin_change_dispenser: expected actuator events are queued
// by the stimulus and checked by an output-edge monitor.
module tb_coin_change_dispenser;
  import vend_pkg::*;

  localparam int W = 19;
  localparam int K_REL = 1, K_DIME = 2, K_NICK = 3, K_FAULT = 4, K_BUSY = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       vend = 1'b0;
  logic [2:0] change = 3'b000;
  logic       nickel_drop = 1'b0;
  logic       dime_drop = 1'b0;
  logic       fault_clear = 1'b0;
  logic       product_release, dime_eject, nickel_eject, busy, fault;
  logic [2:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit dime_en = 1'b0;
  bit nickel_en = 1'b0;

  always #5 clock = ~clock;

  coin_change_dispenser #(.PULSE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clock           (clock),
    .reset           (reset),
    .vend            (vend),
    .change          (change),
    .nickel_drop     (nickel_drop),
    .dime_drop       (dime_drop),
    .fault_clear     (fault_clear),
    .product_release (product_release),
    .dime_eject      (dime_eject),
    .nickel_eject    (nickel_eject),
    .busy            (busy),
    .fault           (fault),
    .state_dbg       (state_dbg)
  );

  // Event word: {kind, pulse width, clocks since last reference point}
  function automatic logic [W-1:0] ev(input int kind, input int width, input int gap);
    return {3'(kind), 8'(width), 8'(gap)};
  endfunction

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_event(input logic [W-1:0] act);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual kind=%0d width=%0d gap=%0d required none at %0t",
               act[18:16], act[15:8], act[7:0], $time);
    end else begin
      exp = exp_q.pop_front();
      if (act != exp) begin
        errors++;
        $display("FAIL event actual kind=%0d width=%0d gap=%0d required kind=%0d width=%0d gap=%0d at %0t",
                 act[18:16], act[15:8], act[7:0], exp[18:16], exp[15:8], exp[7:0], $time);
      end
    end
  endtask

  // Monitor: falls first, then busy/fault rises, then actuator rises
  int n_idx = 0, ref_idx = 0;
  int rise_rel = 0, rise_dime = 0, rise_nick = 0;
  int gap_rel = 0, gap_dime = 0, gap_nick = 0;
  logic p_rel = 1'b0, p_dime = 1'b0, p_nick = 1'b0, p_busy = 1'b0, p_fault = 1'b0;

  always @(negedge clock) begin
    n_idx++;
    if (p_rel && !product_release) begin check_event(ev(K_REL, n_idx - rise_rel, gap_rel)); ref_idx = n_idx; end
    if (p_dime && !dime_eject) begin check_event(ev(K_DIME, n_idx - rise_dime, gap_dime)); ref_idx = n_idx; end
    if (p_nick && !nickel_eject) begin check_event(ev(K_NICK, n_idx - rise_nick, gap_nick)); ref_idx = n_idx; end
    if (!p_busy && busy) ref_idx = n_idx;
    if (p_busy && !busy) check_event(ev(K_BUSY, 0, n_idx - ref_idx));
    if (!p_fault && fault) begin check_event(ev(K_FAULT, 0, n_idx - ref_idx)); ref_idx = n_idx; end
    if (!p_rel && product_release) begin rise_rel = n_idx; gap_rel = n_idx - ref_idx; end
    if (!p_dime && dime_eject) begin rise_dime = n_idx; gap_dime = n_idx - ref_idx; end
    if (!p_nick && nickel_eject) begin rise_nick = n_idx; gap_nick = n_idx - ref_idx; end
    p_rel = product_release; p_dime = dime_eject; p_nick = nickel_eject;
    p_busy = busy; p_fault = fault;
  end

  // Chute sensors: one coin drops 10 clocks after its eject pulse ends
  initial forever begin
    @(negedge dime_eject);
    if (dime_en) begin
      repeat (10) @(posedge clock);
      #1 dime_drop = 1'b1;
      repeat (2) @(posedge clock);
      #1 dime_drop = 1'b0;
    end
  end

  initial forever begin
    @(negedge nickel_eject);
    if (nickel_en) begin
      repeat (10) @(posedge clock);
      #1 nickel_drop = 1'b1;
      repeat (2) @(posedge clock);
      #1 nickel_drop = 1'b0;
    end
  end

  task automatic issue(input logic v, input logic [2:0] c, input bit chk);
    @(posedge clock);
    #1 vend = v; change = c;
    @(posedge clock);
    #1 vend = 1'b0; change = CHANGE_NONE;
    if (chk) check_val("busy_at_capture", int'(busy), 0);
    @(posedge clock);
    #1;
    if (chk) check_val("busy_after_capture", int'(busy), 1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clock);
      #1 k++;
    end
    check_val({name, "_pending_events"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic wait_fault_and_clear();
    int k;
    k = 0;
    while (!fault && k < 200) begin
      @(posedge clock);
      #1 k++;
    end
    check_val("fault_seen", int'(fault), 1);
    check_val("no_actuator_in_fault", int'({product_release, dime_eject, nickel_eject}), 0);
    repeat (3) @(posedge clock);
    #1 fault_clear = 1'b1;
    @(posedge clock);
    #1 fault_clear = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check_val("rst_release", int'(product_release), 0);
    check_val("rst_dime", int'(dime_eject), 0);
    check_val("rst_nickel", int'(nickel_eject), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_fault", int'(fault), 0);
    check_val("rst_state", int'(state_dbg), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // vend + nickel/dime, plus a stray request while busy
    dime_en = 1'b1; nickel_en = 1'b1;
    exp_q.push_back(ev(K_REL, 4, 0));
    exp_q.push_back(ev(K_DIME, 4, 0));
    exp_q.push_back(ev(K_NICK, 4, 15));
    exp_q.push_back(ev(K_BUSY, 0, 15));
    issue(1'b1, NICKEL_DIME, 1'b1);
    repeat (6) @(posedge clock);
    #1 vend = 1'b1; change = NICKEL;
    @(posedge clock);
    #1 vend = 1'b0; change = CHANGE_NONE;
    wait_done("vend_nd");
    check_val("fault_after_vend_nd", int'(fault), 0);

    // two dimes, no product
    exp_q.push_back(ev(K_DIME, 4, 0));
    exp_q.push_back(ev(K_DIME, 4, 15));
    exp_q.push_back(ev(K_BUSY, 0, 15));
    issue(1'b0, DIME_DIME, 1'b1);
    wait_done("dime_dime");

    // product only, then an empty request
    exp_q.push_back(ev(K_REL, 4, 0));
    exp_q.push_back(ev(K_BUSY, 0, 0));
    issue(1'b1, CHANGE_NONE, 1'b1);
    wait_done("vend_only");
    issue(1'b0, CHANGE_NONE, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check_val("idle_busy", int'(busy), 0);
      @(posedge clock);
      #1;
    end

    // dime timeout, clear, then a normal dime
    dime_en = 1'b0;
    exp_q.push_back(ev(K_DIME, 4, 0));
    exp_q.push_back(ev(K_FAULT, 0, 64));
    exp_q.push_back(ev(K_BUSY, 0, 5));
    issue(1'b0, DIME, 1'b1);
    wait_fault_and_clear();
    wait_done("timeout");
    dime_en = 1'b1;
    exp_q.push_back(ev(K_DIME, 4, 0));
    exp_q.push_back(ev(K_BUSY, 0, 15));
    issue(1'b0, DIME, 1'b1);
    wait_done("after_clear");

    // illegal change code
    exp_q.push_back(ev(K_FAULT, 0, 0));
    exp_q.push_back(ev(K_BUSY, 0, 5));
    issue(1'b1, 3'b110, 1'b1);
    check_val("illegal_fault_next", int'(fault), 1);
    wait_fault_and_clear();
    wait_done("illegal");

    // reset in DIME_WAIT, then a single nickel
    begin
      int k;
      dime_en = 1'b0;
      exp_q.push_back(ev(K_DIME, 4, 0));
      exp_q.push_back(ev(K_BUSY, 0, 5));
      issue(1'b0, DIME, 1'b1);
      k = 0;
      while (!dime_eject && k < 50) begin @(posedge clock); #1 k++; end
      while (dime_eject && k < 50) begin @(posedge clock); #1 k++; end
      check_val("dime_pulse_bounded", int'(k < 50), 1);
      repeat (5) @(posedge clock);
      #1 reset = 1'b1;
      #1;
      check_val("async_rst_busy", int'(busy), 0);
      check_val("async_rst_state", int'(state_dbg), 0);
      check_val("async_rst_dime", int'(dime_eject), 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      wait_done("reset_wait");
    end
    exp_q.push_back(ev(K_NICK, 4, 0));
    exp_q.push_back(ev(K_BUSY, 0, 15));
    issue(1'b0, NICKEL, 1'b1);
    wait_done("nickel_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/coin_change_dispenser.md
# coin_change_dispenser

Downstream stage of the vending-machine FSM. Captures the one-cycle `vend` strobe and 3-bit `change` code, then sequences product release and change ejection: timed solenoid pulses for the dime and nickel chutes, each confirmed by a chute drop sensor, with a timeout. It owns the physical actuators and reports `busy`/`fault` back to the controller.

## Interface
- `PULSE_CYCLES`, 4: width of each actuator pulse in clocks; must be ≥1.
- `TIMEOUT_CYCLES`, 64: clocks allowed for a drop-sensor edge after a pulse ends; must be ≥4.
- `clock` in 1: single system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `vend` in 1: product-release request strobe from the FSM.
- `change` in 3: change code. 000 none, 001 nickel, 010 dime, 011 nickel+dime, 100 dime+dime; 101–111 illegal.
- `nickel_drop` in 1: asynchronous nickel-chute sensor; a rising edge means one coin dropped.
- `dime_drop` in 1: asynchronous dime-chute sensor, same rules.
- `fault_clear` in 1: synchronous level; exits FAULT.
- `product_release` out 1: product solenoid pulse.
- `dime_eject` out 1: dime solenoid pulse.
- `nickel_eject` out 1: nickel solenoid pulse.
- `busy` out 1: high in every state except IDLE.
- `fault` out 1: high in FAULT only.

## Operation
- States: IDLE, RELEASE, DIME_PULSE, DIME_WAIT, NICKEL_PULSE, NICKEL_WAIT, FAULT.
- IDLE: a request is `vend`=1 or `change`≠000, sampled only in IDLE. Requests in any other state are ignored and not queued.
- Capture on request:
  - dimes_left/nickels_left are decoded from `change`: 001→0/1, 010→1/0, 011→1/1, 100→2/0, 000→0/0.
  - Illegal code (101–111) goes to FAULT with counts 0, regardless of `vend`.
  - Otherwise the next state is the first that applies, in order: RELEASE if `vend`, DIME_PULSE if dimes_left>0, NICKEL_PULSE if nickels_left>0, else IDLE.
- RELEASE: `product_release`=1 for PULSE_CYCLES clocks. No sensor check. Then goes to DIME_PULSE, NICKEL_PULSE or IDLE using the same priority.
- DIME_PULSE: `dime_eject`=1 for PULSE_CYCLES clocks, then DIME_WAIT.
- DIME_WAIT:
  - On a synchronized dime_drop rising edge, dimes_left is decremented. The next state is DIME_PULSE if dimes_left is still >0, else NICKEL_PULSE if nickels_left>0, else IDLE.
  - If no edge arrives within TIMEOUT_CYCLES clocks, go to FAULT.
- NICKEL_PULSE and NICKEL_WAIT mirror the dime states. On completion they go to IDLE.
- Drop edges are counted only in the matching WAIT state. Edges arriving in any other state are discarded.
- FAULT:
  - All actuators low; `fault`=1; counts cleared.
  - Held until `fault_clear`=1 is sampled, then IDLE on the next clock.
- Each sensor passes through a 2-flop synchronizer followed by a rising-edge detect.
- A shared down-counter serves both pulse width and timeout; width is $clog2(max(PULSE_CYCLES,TIMEOUT_CYCLES)+1).

## Timing
- All outputs are registered Moore outputs decoded from the state register.
- Reset values: every output 0, state IDLE, counts 0, synchronizer and edge flops 0. Values take effect immediately on `reset` assertion, including mid-pulse.
- Capture latency:
  - Request sampled at edge t.
  - `busy` and the first actuator output go high after edge t+1.
  - The actuator stays high for exactly PULSE_CYCLES clocks.
- Sensor latency: a drop input rising before edge s is seen as an edge at s+2 and causes the state change at s+3.
- Timeout: FAULT is entered exactly TIMEOUT_CYCLES clocks after the WAIT state is entered, if no edge arrives.
- A drop edge and timeout expiry on the same cycle count as a drop.
- Back-to-back requests: `busy` falls for at least one cycle (IDLE) between transactions.

## Structure
- Shared package `vend_pkg`:
  - Coin codes NICKEL, DIME, NICKEL_DIME, DIME_DIME, QUARTER.
  - The upstream FSM state constants.
  - The dispenser state enum.
- The upstream FSM and this block both import it.
- One sub-module `drop_sync`: 2-flop synchronizer plus rising-edge pulse, reset to 0. Instantiated twice.

## Test plan
- Defaults. `vend`=1, `change`=011 for one cycle; each sensor pulses 10 clocks after its eject falls → product_release 4 clk, then dime_eject 4 clk, then nickel_eject 4 clk, then `busy`=0, `fault`=0. A second request sent mid-sequence is ignored.
- `change`=100, `vend`=0 → two dime_eject pulses separated by a wait; no nickel_eject or product_release.
- `vend`=1, `change`=000 → a single 4-clk product_release. `vend`=0, `change`=000 → no activity, `busy` stays 0.
- `change`=010 with dime_drop held low → `fault` rises exactly 64 clk after dime_eject falls. `fault_clear` pulse → IDLE; a new request is then serviced normally.
- `change`=110 → FAULT the cycle after capture, no actuator activity.
- `reset` asserted during DIME_WAIT → outputs 0 asynchronously. After release, a `change`=001 request yields one nickel_eject.
